// File: rtl/cdc_hs_arbiter.sv
// cdc_hs_arbiter: round-robin arbiter sequencing one shared four-phase req/ack crossing
module cdc_hs_arbiter #(
  parameter int NREQ = 2,
  parameter int DW = 32,
  parameter int TMO_CYC = 255
) (
  input  logic             clk_m,
  input  logic             reset_m,
  input  logic [NREQ-1:0]  req_i,
  input  logic [NREQ*DW-1:0] data_i,
  output logic [NREQ-1:0]  done_o,
  output logic [NREQ-1:0]  err_o,
  output logic             xreq_o,
  output logic [DW-1:0]    xdata_o,
  input  logic             ack_sync_i,
  output logic             busy_o
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);
  typedef enum logic [2:0] {IDLE, WAIT_HI, WAIT_LO, DONE, ERR, DRAIN} state_t;
  state_t r_state;
  logic [IW-1:0] r_grant, r_last, w_idx;
  logic [7:0] r_cnt;
  logic [1:0] r_dcnt;
  logic [NREQ-1:0] r_done, r_err, w_gmask;
  logic [DW-1:0] r_xdata;
  logic r_xreq, r_busy, w_found, w_tmo;
  assign done_o = r_done;
  assign err_o = r_err;
  assign xreq_o = r_xreq;
  assign xdata_o = r_xdata;
  assign busy_o = r_busy;
  assign w_gmask = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
  assign w_tmo = (TMO_CYC != 0) && (r_cnt == TMO_LAST);
  // round-robin search upward from last+1; walking downward lets the nearest candidate win
  always_comb begin
    w_found = 1'b0;
    w_idx = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req_i[IW'((int'(r_last) + i) % NREQ)]) begin
        w_found = 1'b1;
        w_idx = IW'((int'(r_last) + i) % NREQ);
      end
    end
  end
  // handshake sequencer with registered outputs; done/err pulses are set on entry to DONE/ERR
  always_ff @(posedge clk_m) begin
    if (reset_m) begin
      r_state <= IDLE;
      r_xreq <= 1'b0;
      r_xdata <= '0;
      r_done <= '0;
      r_err <= '0;
      r_busy <= 1'b0;
      r_cnt <= '0;
      r_dcnt <= '0;
      r_grant <= '0;
      r_last <= IW'(NREQ - 1);
    end else begin
      r_done <= '0;
      r_err <= '0;
      case (r_state)
        IDLE: if (w_found) begin
          r_grant <= w_idx;
          r_xdata <= data_i[w_idx*DW +: DW];
          r_xreq <= 1'b1;
          r_busy <= 1'b1;
          r_cnt <= '0;
          r_state <= WAIT_HI;
        end
        WAIT_HI: if (ack_sync_i) begin
          r_xreq <= 1'b0;
          r_cnt <= '0;
          r_state <= WAIT_LO;
        end else if (w_tmo) begin
          r_xreq <= 1'b0;
          r_err <= w_gmask;
          r_state <= ERR;
        end else r_cnt <= r_cnt + 8'd1;
        WAIT_LO: if (!ack_sync_i) begin
          r_done <= w_gmask;
          r_state <= DONE;
        end else if (w_tmo) begin
          r_err <= w_gmask;
          r_state <= ERR;
        end else r_cnt <= r_cnt + 8'd1;
        DONE: begin
          r_last <= r_grant;
          r_busy <= 1'b0;
          r_state <= IDLE;
        end
        ERR: begin
          r_last <= r_grant;
          r_dcnt <= '0;
          r_state <= DRAIN;
        end
        DRAIN: if (ack_sync_i) r_dcnt <= '0;
        else if (r_dcnt == 2'd3) begin
          r_busy <= 1'b0;
          r_state <= IDLE;
        end else r_dcnt <= r_dcnt + 2'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cdc_hs_arbiter.sv
// tb_cdc_hs_arbiter: table-driven and scoreboard checks of the shared handshake arbiter
module tb_cdc_hs_arbiter;
  logic clk, reset_m;
  logic [1:0] req_i, done_o, err_o, req2, done2, err2;
  logic [63:0] data_i, data2;
  logic xreq_o, ack_sync_i, busy_o, xreq2, ack2, busy2;
  logic [31:0] xdata_o, xdata2;
  typedef struct {int idx; logic [31:0] data; bit err;} exp_t;
  typedef struct {int r0; int r1; int ad; int ld; int n; logic [3:0] ord;} vec_t;
  exp_t sbq[$];
  exp_t cur;
  bit cur_v;
  vec_t vt[6];
  int checks, failures;
  int rem[2], cnt[2];
  int ack_dly, lo_dly;
  bit resp_en, prev_xreq;
  logic [1:0] pprev;

  cdc_hs_arbiter #(.NREQ(2), .DW(32), .TMO_CYC(8)) dut (
    .clk_m(clk), .reset_m(reset_m), .req_i(req_i), .data_i(data_i), .done_o(done_o),
    .err_o(err_o), .xreq_o(xreq_o), .xdata_o(xdata_o), .ack_sync_i(ack_sync_i), .busy_o(busy_o));
  cdc_hs_arbiter #(.NREQ(2), .DW(32), .TMO_CYC(4)) dut4 (
    .clk_m(clk), .reset_m(reset_m), .req_i(req2), .data_i(data2), .done_o(done2),
    .err_o(err2), .xreq_o(xreq2), .xdata_o(xdata2), .ack_sync_i(ack2), .busy_o(busy2));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input int k, input int n);
    return 32'hA5A5_0001 + 32'(k * 256 + n);
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // requesters: hold req until the done/err pulse has been seen, then drop or reissue
  initial begin
    req_i = 0;
    data_i = 0;
    rem = '{0, 0};
    cnt = '{0, 0};
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (pprev[k] && rem[k] > 0) begin
          rem[k]--;
          cnt[k]++;
        end
        req_i[k] = rem[k] > 0;
        data_i[k*32 +: 32] = mk(k, cnt[k]);
      end
    end
  end

  // far-side responder: raise ack ack_dly cycles after xreq, drop lo_dly cycles after xreq falls
  initial begin
    int w;
    w = 0;
    ack_sync_i = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) w = 0;
      else if (xreq_o && !ack_sync_i) begin
        if (w >= ack_dly) begin ack_sync_i = 1; w = 0; end else w++;
      end else if (!xreq_o && ack_sync_i) begin
        if (w >= lo_dly) begin ack_sync_i = 0; w = 0; end else w++;
      end
    end
  end

  // scoreboard: pop at each request rise, check payload while held, check completion pulse
  initial begin
    logic [1:0] em;
    prev_xreq = 0;
    pprev = 0;
    forever begin
      @(negedge clk);
      if (xreq_o && !prev_xreq) begin
        if (sbq.size() == 0) cmp("unexpected_grant", {31'd0, xreq_o}, 0);
        else begin
          cur = sbq.pop_front();
          cur_v = 1;
          cmp("xdata_at_grant", xdata_o, cur.data);
        end
      end else if (xreq_o && cur_v) cmp("xdata_stable", xdata_o, cur.data);
      if ((done_o | err_o) != 0) begin
        if (!cur_v) cmp("unexpected_pulse", {done_o, err_o}, 0);
        else begin
          em = 2'b01 << cur.idx;
          cmp("done_pulse", done_o, cur.err ? 2'b00 : em);
          cmp("err_pulse", err_o, cur.err ? em : 2'b00);
          cur_v = 0;
        end
      end
      pprev = done_o | err_o;
      prev_xreq = xreq_o;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_m = 1;
    resp_en = 0;
    ack_sync_i = 0;
    rem = '{0, 0};
    cnt = '{0, 0};
    sbq.delete();
    cur_v = 0;
    repeat (2) @(negedge clk);
    cmp("reset_state", {xreq_o, busy_o, done_o, err_o, xdata_o}, 0);
    reset_m = 0;
  endtask

  task automatic wait_xreq(input bit lvl, input string nm);
    int w;
    w = 0;
    while (xreq_o !== lvl && w < 40) begin
      @(negedge clk);
      w++;
    end
    cmp(nm, {31'd0, xreq_o}, {31'd0, lvl});
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      ok = sbq.size() == 0 && !cur_v && !busy_o && req_i == 0;
      if (ok) break;
      @(negedge clk);
    end
    cmp(nm, {63'd0, ok}, 1);
  endtask

  task automatic push(input int k, input int n, input bit e);
    exp_t x;
    x.idx = k;
    x.data = mk(k, n);
    x.err = e;
    sbq.push_back(x);
  endtask

  task automatic timeout_run(input bit late, input int exp_drain, input string nm);
    int n;
    do_reset();
    push(0, 0, 1);
    rem[0] = 1;
    wait_xreq(1, {nm, "_grant"});
    n = 0;
    for (int i = 0; i < 50 && xreq_o; i++) begin
      n++;
      @(negedge clk);
    end
    cmp({nm, "_xreq_cycles"}, n, 8);
    cmp({nm, "_err_out"}, {done_o, err_o}, 4'b0001);
    n = 0;
    @(negedge clk);
    for (int i = 0; i < 50 && busy_o; i++) begin
      n++;
      @(posedge clk);
      #1 ack_sync_i = late && n == 2;
      @(negedge clk);
    end
    cmp({nm, "_drain_cycles"}, n, exp_drain);
    wait_idle({nm, "_idle"});
  endtask

  initial begin
    int c[2];
    checks = 0;
    failures = 0;
    reset_m = 1;
    resp_en = 0;
    req2 = 0;
    data2 = 0;
    ack2 = 0;
    ack_dly = 0;
    lo_dly = 0;
    vt[0] = '{1, 0, 3, 3, 1, 4'b0000};
    vt[1] = '{1, 1, 1, 1, 2, 4'b0010};
    vt[2] = '{2, 2, 0, 0, 4, 4'b1010};
    vt[3] = '{0, 2, 2, 1, 2, 4'b0011};
    vt[4] = '{3, 1, 1, 0, 4, 4'b0010};
    vt[5] = '{1, 3, 0, 2, 4, 4'b1110};
    for (int v = 0; v < 6; v++) begin
      do_reset();
      ack_dly = vt[v].ad;
      lo_dly = vt[v].ld;
      resp_en = 1;
      c = '{0, 0};
      for (int i = 0; i < vt[v].n; i++) begin
        push(int'(vt[v].ord[i]), c[vt[v].ord[i]], 0);
        c[vt[v].ord[i]]++;
      end
      rem[0] = vt[v].r0;
      rem[1] = vt[v].r1;
      wait_idle($sformatf("vec%0d_complete", v));
    end
    timeout_run(0, 4, "timeout");
    timeout_run(1, 7, "late_ack");
    do_reset();
    ack_dly = 0;
    lo_dly = 3;
    resp_en = 1;
    push(0, 0, 0);
    rem[0] = 1;
    rem[1] = 1;
    wait_xreq(1, "midrst_grant");
    wait_xreq(0, "midrst_ack_hi");
    cmp("midrst_in_wait_lo", {busy_o, ack_sync_i}, 2'b11);
    reset_m = 1;
    resp_en = 0;
    ack_sync_i = 0;
    @(negedge clk);
    cmp("midrst_outputs", {xreq_o, busy_o, done_o, err_o, xdata_o}, 0);
    sbq.delete();
    cur_v = 0;
    push(0, 0, 0);
    push(1, 0, 0);
    reset_m = 0;
    resp_en = 1;
    wait_idle("midrst_regrant");
    @(negedge clk);
    req2 = 2'b01;
    data2 = {32'h0, 32'h1234_5678};
    for (int i = 0; i < 20 && !xreq2; i++) @(negedge clk);
    cmp("tmoedge_xdata", {xreq2, xdata2}, {1'b1, 32'h1234_5678});
    repeat (3) @(posedge clk);
    #1 ack2 = 1;
    @(negedge clk);
    cmp("tmoedge_pre", {xreq2, err2}, 3'b100);
    @(negedge clk);
    cmp("tmoedge_wait_lo", {xreq2, err2, busy2}, 4'b0001);
    @(posedge clk);
    #1 ack2 = 0;
    for (int i = 0; i < 10 && (done2 | err2) == 0; i++) @(negedge clk);
    cmp("tmoedge_done", {done2, err2}, 4'b0100);
    req2 = 0;
    @(negedge clk);
    cmp("tmoedge_idle", {busy2, done2, err2}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cdc_hs_arbiter.md
# cdc_hs_arbiter

Shares one four-phase request/acknowledge crossing between NREQ local requesters in the `clk_m` domain of the LDL Wishbone GPIO path. The block arbitrates round-robin and drives `xreq_o`/`xdata_o` to the far domain. It sequences the full four-phase handshake against the already-synchronized acknowledge from the three-flop ack synchronizer, and reports completion or timeout back to the granted requester.

## Interface
- NREQ, 2: number of requesters; range 2..8.
- DW, 32: payload width.
- TMO_CYC, 255: wait-state timeout in cycles; range 1..255; 0 disables timeout.
- clk_m  in  1  module clock; all logic on rising edge.
- reset_m  in  1  reset; synchronous, active-high.
- req_i  in  NREQ  per-requester level request; held until `done_o` or `err_o` is seen.
- data_i  in  NREQ*DW  per-requester payload; slice k is `data_i[k*DW +: DW]`.
- done_o  out  NREQ  one-cycle completion pulse to the granted requester.
- err_o  out  NREQ  one-cycle timeout pulse to the granted requester.
- xreq_o  out  1  four-phase request to the far domain.
- xdata_o  out  DW  payload to the far domain; stable whenever `xreq_o`=1 or the state is WAIT_LO.
- ack_sync_i  in  1  far-domain acknowledge, already synchronized into `clk_m`.
- busy_o  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, WAIT_HI, WAIT_LO, DONE, ERR, DRAIN. All outputs are registered.
- **IDLE:**
  - If any `req_i` bit is set, grant the first set bit found by searching upward (with wrap) from `last+1`.
  - On grant: latch the grant index and `data_i` slice into `xdata_o`, set `xreq_o`=1, clear the timeout counter, and go to WAIT_HI.
  - `last` resets to NREQ-1, so requester 0 has first priority after reset.
- **WAIT_HI:**
  - `ack_sync_i`=1: set `xreq_o`=0, clear the counter, go to WAIT_LO.
  - Counter reaches TMO_CYC-1 with ack still low: set `xreq_o`=0, go to ERR.
- **WAIT_LO:**
  - `ack_sync_i`=0: go to DONE.
  - Timeout under the same rule: go to ERR.
- **DONE:** `done_o[grant]`=1 for exactly one cycle; update `last` to the grant index; go to IDLE.
- **ERR:** `err_o[grant]`=1 for exactly one cycle; update `last`; go to DRAIN.
- **DRAIN:**
  - A 2-bit counter counts consecutive cycles with `ack_sync_i`=0; any `ack_sync_i`=1 restarts the count.
  - After 4 consecutive low cycles, go to IDLE. This guards against a late ack from the far domain.
  - DRAIN has no timeout.
- **Requester contract:** drop `req_i[k]` on the edge where `done_o[k]` or `err_o[k]` is sampled high.
  - Deassertion of `req_i` during a transfer is ignored; the transfer completes.
  - Changes to `req_i` or `data_i` of the granted requester after grant have no effect.
- **Payload stability:** `xdata_o` changes only in IDLE on a grant.
- **Reset:** state IDLE, `xreq_o`=0, `xdata_o`=0, `done_o`=0, `err_o`=0, `busy_o`=0, counters 0, `last`=NREQ-1.
  - Reset mid-handshake drops `xreq_o` at the next edge.
  - There is no drain after reset; the far side tolerates this.
- **Mutual exclusion:** `done_o` and `err_o` are never high together, and at most one bit of each is set.

## Timing
- **Grant:** `req_i` first sampled high in IDLE at edge t gives `xreq_o`=1 and `busy_o`=1 after edge t.
- **Ack high:** `ack_sync_i` sampled high at edge a gives `xreq_o`=0 after edge a.
- **Ack low:** `ack_sync_i` sampled low at edge b (in WAIT_LO) puts the block in DONE after b and in IDLE after b+1.
  - The next `xreq_o` rises after b+2 at the earliest.
- **Minimum occupancy:** 4 cycles with zero-latency ack. Back-to-back grants have one IDLE cycle between transfers.
- **Timeout:** `xreq_o` rises after edge t. With no ack, the counter counts 0..TMO_CYC-1 over TMO_CYC cycles.
  - `xreq_o` falls and ERR is entered after edge t+TMO_CYC.
  - `err_o` is high during cycle t+TMO_CYC+1.
- **Ack on the timeout edge:** ack sampled high on the same edge where the counter hits TMO_CYC-1 takes priority, so there is no error.
- **Simultaneous requests:** only the round-robin winner is granted; the others wait in order.

## Test plan
- **Single transfer:** reset, `req_i`=2'b01, `data_i[31:0]`=0xA5A5_0001, ack rises 3 cycles after `xreq_o` and falls 3 cycles after `xreq_o` drops.
  - Expect `xdata_o`=0xA5A5_0001 throughout.
  - Expect `done_o`=2'b01 for 1 cycle, then `busy_o`=0.
- **Contention:** `req_i`=2'b11 held, each requester dropping on its done.
  - Expect grant order 0 then 1.
  - Repeating with both held continuously gives 0,1,0,1.
- **Timeout:** TMO_CYC=8, ack tied 0.
  - Expect `xreq_o` high exactly 8 cycles, then `err_o`=2'b01 for 1 cycle.
  - Expect DRAIN for 4 cycles, then IDLE.
- **Late ack in DRAIN:** pulse ack high 2 cycles into DRAIN.
  - Expect the DRAIN count to restart.
  - Expect IDLE only after 4 further low cycles; no `done_o`.
- **Reset mid-handshake:** assert `reset_m` in WAIT_LO.
  - Expect all outputs 0 at the next edge.
  - Expect the next grant to go to requester 0.
- **Ack on the timeout edge:** TMO_CYC=4, ack rises on the 4th wait cycle.
  - Expect WAIT_LO, no `err_o`, and a normal `done_o`.
